event_generator: RTL and testbench

EVENT_GENERATOR -- requirements
Module: event_generator

---
 rtl/event_generator_pkg.sv | 25 ++
 rtl/seven_segment_decoder.sv | 30 +++
 rtl/event_generator.sv | 125 ++++++++++++
 tb/tb_event_generator.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/event_generator_pkg.sv
// Shared encodings and widths for the event generator: FSM states, period-select
// shift table and timer/count widths.
package event_generator_pkg;

    localparam int TIMER_W = 16;
    localparam int COUNT_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        FIRE = 2'd2,
        DONE = 2'd3
    } state_e;

    // Period select S maps to a left shift of the base unit: P = UNIT << S.
    localparam int unsigned PSEL_SHIFT [4] = '{0, 1, 2, 3};

    function automatic logic [TIMER_W-1:0] period_m1(input int unsigned unit,
                                                     input logic [1:0] sel);
        int unsigned p;
        p = unit << PSEL_SHIFT[sel];
        return TIMER_W'(p - 1);
    endfunction

endpackage

// File: rtl/seven_segment_decoder.sv
// Hex digit to active-low seven-segment pattern, bit order gfedcba.
module seven_segment_decoder (
    input  logic [3:0] digit_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = 7'b1111111;
        case (digit_i)
            4'h0: seg_o = 7'b1000000;
            4'h1: seg_o = 7'b1111001;
            4'h2: seg_o = 7'b0100100;
            4'h3: seg_o = 7'b0110000;
            4'h4: seg_o = 7'b0011001;
            4'h5: seg_o = 7'b0010010;
            4'h6: seg_o = 7'b0000010;
            4'h7: seg_o = 7'b1111000;
            4'h8: seg_o = 7'b0000000;
            4'h9: seg_o = 7'b0010000;
            4'hA: seg_o = 7'b0001000;
            4'hB: seg_o = 7'b0000011;
            4'hC: seg_o = 7'b1000110;
            4'hD: seg_o = 7'b0100001;
            4'hE: seg_o = 7'b0000110;
            4'hF: seg_o = 7'b0001110;
            default: seg_o = 7'b1111111;
        endcase
    end

endmodule

// File: rtl/event_generator.sv
// Emits N single-cycle EVENT_OUT pulses spaced P = UNIT << S cycles apart after
// a synchronized KEY[0] start; remaining/busy/done shown on LEDR and HEX0.
module event_generator
    import event_generator_pkg::*;
#(
    parameter int unsigned UNIT = 4
) (
    input  logic       CLOCK_50,
    input  logic [3:0] KEY,
    input  logic [9:0] SW,
    output logic       EVENT_OUT,
    output logic [9:0] LEDR,
    output logic [6:0] HEX0
);

    logic unused_keys;
    assign unused_keys = ^KEY[3:2];

    // Reset asserts asynchronously, releases on a clock edge.
    logic [1:0] rst_sync_q;
    logic       rst_n;

    always_ff @(posedge CLOCK_50 or negedge KEY[1]) begin
        if (!KEY[1]) rst_sync_q <= 2'b00;
        else         rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
    assign rst_n = rst_sync_q[1];

    // Start detect is armed only after the synchronizer has seen KEY[0] low
    // post-reset, so a key held through reset release never starts a run.
    logic [1:0] key_sync_q;
    logic       key_prev_q;
    logic [1:0] settle_q;
    logic       armed_q;
    logic       start;

    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            key_sync_q <= 2'b00;
            key_prev_q <= 1'b0;
            settle_q   <= 2'b00;
            armed_q    <= 1'b0;
        end else begin
            key_sync_q <= {key_sync_q[0], KEY[0]};
            key_prev_q <= key_sync_q[1];
            settle_q   <= {settle_q[0], 1'b1};
            armed_q    <= armed_q | (settle_q[1] & ~key_sync_q[1]);
        end
    end

    assign start = key_sync_q[1] & ~key_prev_q & armed_q;

    state_e               state_q, state_d;
    logic [TIMER_W-1:0]   timer_q, timer_d;
    logic [COUNT_W-1:0]   rem_q, rem_d;
    logic [1:0]           sel_q, sel_d;
    logic                 done_q, done_d;

    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            timer_q <= '0;
            rem_q   <= '0;
            sel_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            rem_q   <= rem_d;
            sel_q   <= sel_d;
            done_q  <= done_d;
        end
    end

    // WAIT spans P-1 cycles and FIRE one, so pulses land exactly P cycles apart.
    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        rem_d   = rem_q;
        sel_d   = sel_q;
        done_d  = done_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    done_d = 1'b0;
                    sel_d  = SW[9:8];
                    if (SW[7:0] == '0) begin
                        state_d = DONE;
                    end else begin
                        rem_d   = SW[7:0];
                        timer_d = period_m1(UNIT, SW[9:8]);
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                if (timer_q != '0) timer_d = timer_q - 1'b1;
                if (timer_q <= 1) state_d = FIRE;
            end
            FIRE: begin
                if (rem_q != '0) rem_d = rem_q - 1'b1;
                if (rem_q <= 1) begin
                    state_d = DONE;
                end else begin
                    timer_d = period_m1(UNIT, sel_q);
                    state_d = WAIT;
                end
            end
            DONE: begin
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign EVENT_OUT = (state_q == FIRE);
    assign LEDR      = {done_q, (state_q == WAIT) || (state_q == FIRE), rem_q};

    seven_segment_decoder u_hex0 (
        .digit_i (rem_q[3:0]),
        .seg_o   (HEX0)
    );

endmodule

// File: tb/tb_event_generator.sv
// Scoreboard bench for event_generator (UNIT=4): expected pulses are queued at
// start and matched against each observed EVENT_OUT by a negedge monitor.
module tb_event_generator;

    localparam int UNIT = 4;

    logic       CLOCK_50;
    logic [3:0] KEY;
    logic [9:0] SW;
    logic       EVENT_OUT;
    logic [9:0] LEDR;
    logic [6:0] HEX0;

    event_generator #(.UNIT(UNIT)) dut (
        .CLOCK_50  (CLOCK_50),
        .KEY       (KEY),
        .SW        (SW),
        .EVENT_OUT (EVENT_OUT),
        .LEDR      (LEDR),
        .HEX0      (HEX0)
    );

    typedef struct {
        int cyc;
        int rem;
    } exp_t;

    exp_t       q[$];
    int         cyc;
    int         n_tests;
    int         n_fail;
    logic       prev_ev;
    logic [6:0] seg_tab [16];

    initial begin
        CLOCK_50 = 1'b0;
        forever #5 CLOCK_50 = ~CLOCK_50;
    end

    initial begin
        cyc = 0;
        forever begin
            @(posedge CLOCK_50);
            cyc = cyc + 1;
        end
    end

    initial begin
        seg_tab = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
    end

    // Pulse monitor: every pulse must match the head of the scoreboard.
    initial begin
        exp_t e;
        prev_ev = 1'b0;
        forever begin
            @(negedge CLOCK_50);
            if (EVENT_OUT === 1'b1) begin
                n_tests++;
                if (prev_ev === 1'b1) begin
                    n_fail++;
                    $display("FAIL pulse_width: EVENT_OUT high 2 cycles at cyc %0d", cyc);
                end
                n_tests++;
                if (q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_pulse: pulse at cyc %0d, none expected", cyc);
                end else begin
                    e = q.pop_front();
                    if (cyc !== e.cyc || int'(LEDR[7:0]) !== e.rem ||
                        HEX0 !== seg_tab[e.rem % 16]) begin
                        n_fail++;
                        $display("FAIL pulse_match: got cyc %0d rem %0d hex %b, want cyc %0d rem %0d hex %b",
                                 cyc, LEDR[7:0], HEX0, e.cyc, e.rem, seg_tab[e.rem % 16]);
                    end
                end
            end
            prev_ev = EVENT_OUT;
        end
    end

    // Drive a KEY[0] pulse and queue the expected pulse schedule:
    // 2 sync cycles + P per pulse, remaining shown pre-decrement.
    task automatic start_run(input logic [9:0] sw, input int npush, output int c);
        int p;
        int n;
        @(negedge CLOCK_50);
        SW     = sw;
        KEY[0] = 1'b1;
        c      = cyc;
        p      = UNIT << sw[9:8];
        n      = int'(sw[7:0]);
        for (int k = 1; k <= npush; k++) q.push_back('{c + 2 + p * k, n - k + 1});
        repeat (3) @(negedge CLOCK_50);
        KEY[0] = 1'b0;
    endtask

    task automatic wait_drain(input int budget, input string name);
        int b;
        b = 0;
        while (q.size() != 0 && b < budget) begin
            @(negedge CLOCK_50);
            b++;
        end
        repeat (4) @(negedge CLOCK_50);
        n_tests++;
        if (q.size() !== 0) begin
            n_fail++;
            $display("FAIL %s_drain: %0d pulses missing, want 0", name, q.size());
        end
        q.delete();
    endtask

    task automatic test_reset;
        KEY = 4'b0000;
        SW  = 10'h000;
        repeat (3) @(negedge CLOCK_50);
        n_tests++;
        if (EVENT_OUT !== 1'b0 || LEDR !== 10'h000 || HEX0 !== 7'b1000000) begin
            n_fail++;
            $display("FAIL reset_state: ev %b ledr %h hex %b, want 0 000 1000000",
                     EVENT_OUT, LEDR, HEX0);
        end
        KEY[1] = 1'b1;
        repeat (8) @(negedge CLOCK_50);
    endtask

    task automatic test_basic;
        int c;
        start_run(10'h003, 3, c);
        wait_drain(100, "basic");
        n_tests++;
        if (LEDR !== 10'h200 || HEX0 !== 7'b1000000) begin
            n_fail++;
            $display("FAIL basic_done: ledr %h hex %b, want 200 1000000", LEDR, HEX0);
        end
    endtask

    task automatic test_long_period;
        int c;
        start_run(10'h305, 5, c);
        wait_drain(400, "long");
        n_tests++;
        if (LEDR !== 10'h200) begin
            n_fail++;
            $display("FAIL long_done: ledr %h, want 200", LEDR);
        end
    endtask

    task automatic test_zero;
        bit saw_clear;
        bit saw_set;
        saw_clear = 0;
        saw_set   = 0;
        @(negedge CLOCK_50);
        SW     = 10'h000;
        KEY[0] = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge CLOCK_50);
            if (LEDR[9] === 1'b0) saw_clear = 1;
            else if (saw_clear && LEDR[9] === 1'b1) saw_set = 1;
        end
        KEY[0] = 1'b0;
        n_tests++;
        if (!saw_set) begin
            n_fail++;
            $display("FAIL zero_done: done re-set seen %0d (clear %0d), want 1", saw_set, saw_clear);
        end
        repeat (20) @(negedge CLOCK_50);
        n_tests++;
        if (LEDR !== 10'h200) begin
            n_fail++;
            $display("FAIL zero_idle: ledr %h, want 200", LEDR);
        end
    endtask

    task automatic test_midrun_ignore;
        int c;
        start_run(10'h014, 20, c);
        repeat (30) @(negedge CLOCK_50);
        SW     = 10'h0FF;
        KEY[0] = 1'b1;
        repeat (3) @(negedge CLOCK_50);
        KEY[0] = 1'b0;
        wait_drain(200, "midrun");
        repeat (10) @(negedge CLOCK_50);
        n_tests++;
        if (LEDR !== 10'h200) begin
            n_fail++;
            $display("FAIL midrun_done: ledr %h, want 200 (no restart)", LEDR);
        end
    endtask

    task automatic test_reset_midrun;
        int c;
        int b;
        start_run(10'h00A, 2, c);
        b = 0;
        while (cyc < c + 2 + 2 * UNIT + 2 && b < 100) begin
            @(negedge CLOCK_50);
            b++;
        end
        n_tests++;
        if (q.size() !== 0 || LEDR !== 10'h108) begin
            n_fail++;
            $display("FAIL pre_reset: pending %0d ledr %h, want 0 108", q.size(), LEDR);
        end
        KEY[1] = 1'b0;
        #1;
        n_tests++;
        if (EVENT_OUT !== 1'b0 || LEDR !== 10'h000 || HEX0 !== 7'b1000000) begin
            n_fail++;
            $display("FAIL reset_midrun: ev %b ledr %h hex %b, want 0 000 1000000",
                     EVENT_OUT, LEDR, HEX0);
        end
        repeat (3) @(negedge CLOCK_50);
        KEY[1] = 1'b1;
        repeat (60) @(negedge CLOCK_50);
        n_tests++;
        if (LEDR !== 10'h000) begin
            n_fail++;
            $display("FAIL post_reset_idle: ledr %h, want 000", LEDR);
        end
    endtask

    task automatic test_key_high_at_reset;
        int c;
        @(negedge CLOCK_50);
        KEY[1] = 1'b0;
        KEY[0] = 1'b1;
        repeat (3) @(negedge CLOCK_50);
        KEY[1] = 1'b1;
        repeat (20) @(negedge CLOCK_50);
        n_tests++;
        if (LEDR !== 10'h000) begin
            n_fail++;
            $display("FAIL key_high_reset: ledr %h, want 000 (no start)", LEDR);
        end
        KEY[0] = 1'b0;
        repeat (8) @(negedge CLOCK_50);
        start_run(10'h102, 2, c);
        wait_drain(100, "rearm");
        n_tests++;
        if (LEDR !== 10'h200) begin
            n_fail++;
            $display("FAIL rearm_done: ledr %h, want 200", LEDR);
        end
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        test_reset();
        test_basic();
        test_long_period();
        test_zero();
        test_midrun_ignore();
        test_reset_midrun();
        test_key_high_at_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
